dmi_jtag_arbiter: RTL
=====================

# dmi_jtag_arbiter

Shares the single TCK-domain DMI port in front of the DMI clock-domain crossing between two requesters. Requester 0 is the JTAG DTM front end; requester 1 is a second debug master, such as a scan-chain sequencer. The block grants requests round-robin and keeps exactly one transaction outstanding. It routes each response back to the requester that owns it, and it recovers from a lost response with a programmable timeout.

## Interface
- `TimeoutCycles`, default 1024: TCK cycles allowed in WaitResp before a synthetic error response; 0 disables the timeout.
- `CntWidth`, default `$clog2(TimeoutCycles+1)`: width of the timeout counter.

Ports:
- `tck_i`: in, 1, JTAG clock; every register in the block is clocked by it.
- `trst_ni`: in, 1, reset, asynchronous, active-low.
- `clear_i`: in, 1, synchronous abort; forces Idle from any state.
- `req{0,1}_i`: in, `dm::dmi_req_t`, request from requester n.
- `req_valid{0,1}_i`: in, 1, request valid from requester n.
- `req_ready{0,1}_o`: out, 1, request accepted from requester n.
- `resp{0,1}_o`: out, `dm::dmi_resp_t`, routed response to requester n.
- `resp_valid{0,1}_o`: out, 1, response valid to requester n.
- `resp_ready{0,1}_i`: in, 1, requester n ready for the response.
- `dmi_req_o`, `dmi_req_valid_o`, `dmi_req_ready_i`: request handshake towards the CDC.
- `dmi_resp_i`, `dmi_resp_valid_i`, `dmi_resp_ready_o`: response handshake from the CDC.
- `timeout_o`: out, 1, one-cycle pulse when a timeout fires.
- `busy_o`: out, 1, high whenever the state is not Idle.

## Operation
- State machine states: Idle, Req, WaitResp, Deliver, Drain.
- Every granted request, read or write, yields exactly one downstream response; the arbiter holds the lock until that response arrives.
- **Idle:**
  - If any `req_valid` is high, pick a winner.
  - Only one valid: that requester wins.
  - Both valid: the requester other than `last_q` wins.
  - Assert `req_ready` of the winner only, combinationally, in the same cycle.
  - Register the request and owner, then go to Req.
- **Req:**
  - `dmi_req_valid_o` = 1 and `dmi_req_o` = registered request, held stable.
  - When `dmi_req_ready_i` is high, go to WaitResp and clear the counter.
- **WaitResp:**
  - `dmi_resp_ready_o` = 1 and the counter increments every cycle.
  - On `dmi_resp_valid_i`: capture `dmi_resp_i` and go to Deliver.
  - Else if `TimeoutCycles` ≠ 0 and count == `TimeoutCycles`-1:
    - capture {data='0, resp=`dm::DTM_ERR`};
    - pulse `timeout_o`;
    - set `stale_q`;
    - go to Deliver.
- **Deliver:**
  - `resp_valid` of the owner = 1, carrying the captured response; the other requester's `resp_valid` stays 0.
  - On the owner's `resp_ready`: set `last_q` = owner.
  - Then go to Drain if `stale_q` is set, otherwise to Idle.
- **Drain:**
  - `dmi_resp_ready_o` = 1 and no grants are issued.
  - A late `dmi_resp_valid_i` is discarded; `stale_q` clears and the state goes to Idle.
- **`clear_i`** (highest priority):
  - Forces Idle and clears `stale_q` and the counter.
  - Any response in flight is lost; the issuing agent is responsible for resetting the CDC as well.
- `dmi_resp_ready_o` is 0 in Idle, Req and Deliver.
- A downstream response arriving in those states violates the protocol: it is ignored and has no effect.

## Timing
- Reset values of every output are 0, except `dmi_req_o` and `resp{0,1}_o`, which are '0. Internal: state Idle, `last_q` = 1 (so requester 0 wins the first tie), `stale_q` = 0.
- Grant latency: `req_ready` is asserted in the first Idle cycle with valid; `dmi_req_valid_o` rises on the next edge.
- Minimum round trip is 4 cycles: Idle → Req → WaitResp → Deliver → Idle, with zero-wait ready and response.
- Back-to-back: the next grant comes no earlier than the cycle after Deliver completes.
- A requester that keeps `req_valid` high across the handshake is re-arbitrated fairly against the other; strict alternation applies under continuous contention.
- Reset asserted mid-transaction returns the block to Idle immediately and asynchronously; no response is delivered.

## Structure
- Add to the `dm` package: `dmi_arb_state_e`.
- `dm::dtm_op_status_e` (DTM_ERR) is reused from `dm`; no new constants.
- Single module, no sub-module. The round-robin pick is two lines and does not justify an `rr_arb` instance.
- Placement: between `dmi_jtag`'s request/response path and `dmi_cdc`.

## Test plan
- **Single read:** requester 0 issues a read at addr 0x10; the CDC replies data 0xDEADBEEF, resp 0 after 3 cycles. Required: `resp0_o` carries that response, `resp_valid1_o` never rises, and `busy_o` is high for 6 cycles.
- **Contention:** both requesters hold valid continuously for 6 requests. Required: grants go 0,1,0,1,0,1 and each response is routed to its issuer.
- **Timeout:** `TimeoutCycles`=8 and the CDC never responds. Required:
  - `timeout_o` pulses exactly 8 cycles after entry to WaitResp;
  - the owner receives resp=DTM_ERR with data 0;
  - the block stays in Drain;
  - a late CDC response is consumed with `resp_valid{0,1}_o` staying 0, then the block returns to Idle.
- **Backpressure:** `dmi_req_ready_i` is held low for 5 cycles and `resp_ready0_i` low for 3 cycles. Required: `dmi_req_o` and `resp0_o` stay stable, and nothing is lost.
- **`clear_i` / reset:** assert `clear_i` in WaitResp, then pulse `trst_ni` in Req. Required: each time the block returns to Idle with all outputs 0, and the next request completes normally.

Source files
------------

// File: rtl/dm_pkg.sv
// Debug-module types shared by the DTM, the DMI arbiter and the DMI CDC.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DTM_SUCCESS = 2'h0,
    DTM_ERR     = 2'h2,
    DTM_BUSY    = 2'h3
  } dtm_op_status_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT_RESP,
    ARB_DELIVER,
    ARB_DRAIN
  } dmi_arb_state_e;

endpackage

// File: rtl/dmi_jtag_arbiter.sv
// Round-robin sharing of the TCK-domain DMI port between two debug masters,
// one transaction outstanding, with timeout recovery for lost responses.
module dmi_jtag_arbiter
  import dm::*;
#(
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned CntWidth      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic      tck_i,
  input  logic      trst_ni,
  input  logic      clear_i,
  input  dmi_req_t  req0_i,
  input  logic      req_valid0_i,
  output logic      req_ready0_o,
  input  dmi_req_t  req1_i,
  input  logic      req_valid1_i,
  output logic      req_ready1_o,
  output dmi_resp_t resp0_o,
  output logic      resp_valid0_o,
  input  logic      resp_ready0_i,
  output dmi_resp_t resp1_o,
  output logic      resp_valid1_o,
  input  logic      resp_ready1_i,
  output dmi_req_t  dmi_req_o,
  output logic      dmi_req_valid_o,
  input  logic      dmi_req_ready_i,
  input  dmi_resp_t dmi_resp_i,
  input  logic      dmi_resp_valid_i,
  output logic      dmi_resp_ready_o,
  output logic      timeout_o,
  output logic      busy_o
);

  dmi_arb_state_e      state_q;
  dmi_req_t            req_q;
  dmi_resp_t           resp_q;
  logic                owner_q;
  logic                last_q;
  logic                stale_q;
  logic                timeout_q;
  logic [CntWidth-1:0] cnt_q;

  logic any_valid;
  logic winner;
  logic grant;
  logic owner_ready;
  logic cnt_hit;

  // On a tie the requester that was not served last wins.
  assign any_valid = req_valid0_i | req_valid1_i;
  assign winner    = (req_valid0_i & req_valid1_i) ? ~last_q : req_valid1_i;
  assign grant     = (state_q == ARB_IDLE) & any_valid & ~clear_i;

  assign req_ready0_o = grant & ~winner;
  assign req_ready1_o = grant & winner;

  assign owner_ready = owner_q ? resp_ready1_i : resp_ready0_i;

  if (TimeoutCycles != 0) begin : g_timeout
    assign cnt_hit = (cnt_q == CntWidth'(TimeoutCycles - 1));
  end else begin : g_no_timeout
    assign cnt_hit = 1'b0;
  end

  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      state_q   <= ARB_IDLE;
      req_q     <= '0;
      resp_q    <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      stale_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      if (clear_i) begin
        state_q <= ARB_IDLE;
        stale_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          ARB_IDLE: begin
            if (grant) begin
              req_q   <= winner ? req1_i : req0_i;
              owner_q <= winner;
              state_q <= ARB_REQ;
            end
          end
          ARB_REQ: begin
            if (dmi_req_ready_i) begin
              cnt_q   <= '0;
              state_q <= ARB_WAIT_RESP;
            end
          end
          ARB_WAIT_RESP: begin
            cnt_q <= cnt_q + CntWidth'(1);
            if (dmi_resp_valid_i) begin
              resp_q  <= dmi_resp_i;
              state_q <= ARB_DELIVER;
            end else if (cnt_hit) begin
              // The real response may still turn up; Drain swallows it.
              resp_q.data <= '0;
              resp_q.resp <= DTM_ERR;
              timeout_q   <= 1'b1;
              stale_q     <= 1'b1;
              state_q     <= ARB_DELIVER;
            end
          end
          ARB_DELIVER: begin
            if (owner_ready) begin
              last_q  <= owner_q;
              state_q <= stale_q ? ARB_DRAIN : ARB_IDLE;
            end
          end
          ARB_DRAIN: begin
            if (dmi_resp_valid_i) begin
              stale_q <= 1'b0;
              state_q <= ARB_IDLE;
            end
          end
          default: state_q <= ARB_IDLE;
        endcase
      end
    end
  end

  assign dmi_req_valid_o  = (state_q == ARB_REQ);
  assign dmi_req_o        = dmi_req_valid_o ? req_q : '0;
  assign dmi_resp_ready_o = (state_q == ARB_WAIT_RESP) | (state_q == ARB_DRAIN);
  assign resp_valid0_o    = (state_q == ARB_DELIVER) & ~owner_q;
  assign resp_valid1_o    = (state_q == ARB_DELIVER) & owner_q;
  assign resp0_o          = resp_valid0_o ? resp_q : '0;
  assign resp1_o          = resp_valid1_o ? resp_q : '0;
  assign timeout_o        = timeout_q;
  assign busy_o           = (state_q != ARB_IDLE);

endmodule
